zwait_spi: RTL and testbench
============================

# zwait_spi

SPI slave bridge that services Z80 wait cycles on behalf of the external MCU. It sits directly downstream of the Z80 wait generator: it consumes that generator's `spiint_n`, `wait_status` and `wait_status_wrn` plus the latched Z80 port address and write data. It exposes them to the MCU over a mode-0 SPI link, accepts the read-response byte and produces the `wait_end` strobe that releases the stalled cycle.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `spi_sck`, `spi_cs_n` and `spi_mosi`; legal range 2..3.

Ports:
- `clk` in 1: system clock; must run at least 4x `spi_sck`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `spi_sck` in 1: SPI clock from the MCU, asynchronous to `clk`.
- `spi_cs_n` in 1: SPI select, active-low.
- `spi_mosi` in 1: serial data from the MCU.
- `spi_miso` out 1: serial data to the MCU.
- `spiint_n` in 1: wait-pending flag from the wait generator, active-low.
- `wait_status` in 2: wait source or DMA device select.
- `wait_status_wrn` in 1: direction of the stalled cycle; 0 = Z80 write.
- `wait_addr` in 8: latched Z80 port address.
- `wait_wdata` in 8: latched Z80 write data.
- `wait_rdata` out 8: response byte for a Z80 read.
- `wait_end` out 1: one-`clk` pulse that terminates the wait.

## Operation

- Inputs `spi_sck`, `spi_cs_n` and `spi_mosi` pass through `SYNC_STAGES` flops each.
- Edges of `spi_sck` are detected from the last two synchronized samples.
- SPI mode 0, MSB first. MOSI is sampled on SCK rising edges. MISO changes on SCK falling edges.
- State machine:
  - IDLE: waiting for a session; `spi_cs_n` high.
  - CMD: `spi_cs_n` falling edge -> CMD, bit counter = 0. Shift MOSI in on each rising edge. On the 8th rising edge, latch the command, load the TX shift register with the response byte, and go to DATA.
  - DATA: shift MISO out on falling edges and MOSI in on rising edges. Every 8th rising edge completes a byte, then the counter wraps and the TX register reloads with the same response.
  - DONE: entered on `spi_cs_n` rise. Execute the deferred action, then return to IDLE on the next clk.
- Commands and their responses:
  - 0x01 STATUS: response `{!spiint_n, wait_status_wrn, 4'b0, wait_status}`, sampled at command latch.
  - 0x02 ADDR: response `wait_addr`.
  - 0x03 WDATA: response `wait_wdata`.
  - 0x04 RDATA: response 0xFF. The first completed data byte is written to `wait_rdata`. Any later bytes are ignored.
  - 0x05 END: response 0xFF. A `wait_end` pulse is deferred to DONE.
  - Any other command: response 0xFF, with no side effects.
- `wait_end` fires only if the END command byte completed (8 bits) before `spi_cs_n` rose.
- A `spi_cs_n` rise mid-byte, in either CMD or DATA, discards the partial byte:
  - no `wait_rdata` update for a partial RDATA byte;
  - a partial command byte gives no `wait_end`;
  - a completed END command still fires `wait_end`.
- SCK edges while `spi_cs_n` is high are ignored.
- A `spi_cs_n` fall while in DONE is honoured after DONE completes, within 1 clk.
- If `spiint_n` is high during END, `wait_end` is still pulsed. The wait generator is the owner of idempotence.

## Timing

- Reset values:
  - `spi_miso` = 0
  - `wait_rdata` = 0xFF
  - `wait_end` = 0
  - state = IDLE
  - bit counter = 0
- Reset takes effect asynchronously. Release is synchronous on the next `clk`.
- Reset mid-session aborts it; no `wait_end` is produced.
- Edge detection latency: `SYNC_STAGES` + 1 clk after the pin transition.
- MSB of the response appears on `spi_miso` within `SYNC_STAGES` + 2 clk after the 8th SCK falling edge. This falling edge is the one that follows the 8th rising edge.
- `spi_miso` holds each bit until the next detected falling edge. It holds the last driven bit while `spi_cs_n` is high.
- `wait_rdata` updates 1 clk after the 16th detected rising edge. It is stable thereafter until the next RDATA write or reset.
- `wait_end` is high exactly 1 clk, `SYNC_STAGES` + 2 clk after the `spi_cs_n` rising pin edge.

## Test plan

- STATUS readout: reset, then drive `spiint_n`=0, `wait_status`=2'b10, `wait_status_wrn`=1. Send 0x01 and clock 8 more bits -> MISO byte reads 0xC2 and no `wait_end`.
- Write-cycle service:
  - set `wait_addr`=0x5A and `wait_wdata`=0x3C;
  - send session 0x02 -> reads 0x5A;
  - send session 0x03 -> reads 0x3C;
  - send session 0x05 -> exactly one `wait_end` pulse after CS rise.
- Read-cycle service: send 0x04 then 0xA7 in one session, then an END session -> `wait_rdata`=0xA7 before `wait_end` pulses once.
- Abort: send 0x04 and 5 bits of 0x11, then raise CS -> `wait_rdata` unchanged at 0xFF. Send 4 bits of 0x05, then raise CS -> no `wait_end`.
- Unknown command 0x7E with 8 data bits -> MISO 0xFF, no `wait_rdata` change, no `wait_end`. Pulse `rst_n` low mid-END-byte -> all outputs at reset values and no pulse.
- Back-to-back sessions with CS high for 1 SCK period, SCK = `clk`/4: END then STATUS -> one `wait_end` and correct status byte.

Source files
------------

// File: rtl/zwait_spi.sv
// zwait_spi: mode-0 SPI slave that lets an MCU service Z80 wait cycles.
// The first byte is a command; the response byte then repeats on MISO.
module zwait_spi #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic       spiint_n,
    input  logic [1:0] wait_status,
    input  logic       wait_status_wrn,
    input  logic [7:0] wait_addr,
    input  logic [7:0] wait_wdata,
    output logic [7:0] wait_rdata,
    output logic       wait_end
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_ADDR   = 8'h02;
    localparam logic [7:0] CMD_WDATA  = 8'h03;
    localparam logic [7:0] CMD_RDATA  = 8'h04;
    localparam logic [7:0] CMD_END    = 8'h05;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] resp_q, resp_d;
    logic [7:0] tx_q, tx_d;
    logic       miso_q, miso_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rd_done_q, rd_done_d;
    logic       end_pend_q, end_pend_d;
    logic       wait_end_q, wait_end_d;

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall;
    logic [7:0] rx_next;
    logic [7:0] resp_sel;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign rx_next  = {rx_q[6:0], mosi_s};

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_prev_d  = sck_s;
    end

    // Response is chosen from the byte being completed, so STATUS
    // reflects the wait generator at the instant the command latches.
    always_comb begin
        resp_sel = 8'hFF;
        if (rx_next == CMD_STATUS) begin
            resp_sel = {~spiint_n, wait_status_wrn, 4'b0000, wait_status};
        end else if (rx_next == CMD_ADDR) begin
            resp_sel = wait_addr;
        end else if (rx_next == CMD_WDATA) begin
            resp_sel = wait_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        cmd_d      = cmd_q;
        resp_d     = resp_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        rdata_d    = rdata_q;
        rd_done_d  = rd_done_q;
        end_pend_d = end_pend_q;
        wait_end_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!cs_s) begin
                    state_d    = ST_CMD;
                    cnt_d      = 3'd0;
                    rd_done_d  = 1'b0;
                    end_pend_d = 1'b0;
                end
            end
            ST_CMD: begin
                if (cs_s) begin
                    state_d = ST_DONE;
                end else if (sck_rise) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        cmd_d      = rx_next;
                        resp_d     = resp_sel;
                        tx_d       = resp_sel;
                        end_pend_d = (rx_next == CMD_END);
                        state_d    = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (cs_s) begin
                    state_d = ST_DONE;
                end else if (sck_rise) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        tx_d = resp_q;
                        if (cmd_q == CMD_RDATA && !rd_done_q) begin
                            rdata_d   = rx_next;
                            rd_done_d = 1'b1;
                        end
                    end
                end else if (sck_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
            ST_DONE: begin
                wait_end_d = end_pend_q;
                end_pend_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            rx_q        <= 8'h00;
            cmd_q       <= 8'h00;
            resp_q      <= 8'hFF;
            tx_q        <= 8'hFF;
            miso_q      <= 1'b0;
            rdata_q     <= 8'hFF;
            rd_done_q   <= 1'b0;
            end_pend_q  <= 1'b0;
            wait_end_q  <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            cmd_q       <= cmd_d;
            resp_q      <= resp_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            rdata_q     <= rdata_d;
            rd_done_q   <= rd_done_d;
            end_pend_q  <= end_pend_d;
            wait_end_q  <= wait_end_d;
        end
    end

    assign spi_miso   = miso_q;
    assign wait_rdata = rdata_q;
    assign wait_end   = wait_end_q;
endmodule

// File: tb/tb_zwait_spi.sv
// tb_zwait_spi: SPI master driving zwait_spi, checked against a
// session-level model of command responses, RDATA writes and END pulses.
module tb_zwait_spi;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spiint_n = 1'b1;
    logic [1:0] wait_status = 2'b00;
    logic       wait_status_wrn = 1'b0;
    logic [7:0] wait_addr = 8'h00;
    logic [7:0] wait_wdata = 8'h00;
    logic [7:0] wait_rdata;
    logic       wait_end;

    zwait_spi #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spiint_n(spiint_n), .wait_status(wait_status),
        .wait_status_wrn(wait_status_wrn),
        .wait_addr(wait_addr), .wait_wdata(wait_wdata),
        .wait_rdata(wait_rdata), .wait_end(wait_end)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int cs_rise_cyc = 0;
    int pulses = 0;
    int m_pulses = 0;
    logic [7:0] m_rdata = 8'hFF;
    logic quiet = 1'b0;
    logic we_prev = 1'b0;
    logic [7:0] tx_b[$];
    logic [7:0] rx_b[$];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare: END pulse latency/width and RDATA stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wait_end) begin
                pulses++;
                chk("wend_latency", cyc - cs_rise_cyc, SYNC + 2);
                chk("wend_width", int'(we_prev), 0);
            end
            if (quiet) chk("rdata_hold", int'(wait_rdata), int'(m_rdata));
        end
        we_prev = wait_end;
    end

    function automatic logic [7:0] model_resp(input logic [7:0] c);
        case (c)
            8'h01: return {~spiint_n, wait_status_wrn, 4'b0000, wait_status};
            8'h02: return wait_addr;
            8'h03: return wait_wdata;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic cs_start(input int hp);
        quiet = 1'b0;
        spi_cs_n = 1'b0;
        repeat (hp) @(negedge clk);
    endtask

    task automatic cs_stop(input int hp);
        repeat (hp) @(negedge clk);
        spi_cs_n = 1'b1;
        cs_rise_cyc = cyc;
    endtask

    task automatic clock_bits(input int nbits, input int hp);
        logic [7:0] cur;
        logic [7:0] sh;
        sh = 8'h00;
        rx_b.delete();
        for (int i = 0; i < nbits; i++) begin
            cur = (i / 8 < tx_b.size()) ? tx_b[i / 8] : 8'h00;
            spi_mosi = cur[7 - (i % 8)];
            repeat (hp) @(negedge clk);
            spi_sck = 1'b1;
            repeat (hp) @(negedge clk);
            if (i >= 8) begin
                sh = {sh[6:0], spi_miso};
                if (i % 8 == 7) rx_b.push_back(sh);
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic session(input int nbits, input int hp);
        logic [7:0] c;
        logic [7:0] r;
        int nfull;
        cs_start(hp);
        clock_bits(nbits, hp);
        cs_stop(hp);
        c = tx_b[0];
        r = model_resp(c);
        nfull = (nbits >= 8) ? (nbits - 8) / 8 : 0;
        for (int i = 0; i < nfull && i < rx_b.size(); i++)
            chk("miso_byte", int'(rx_b[i]), int'(r));
        if (nbits >= 8 && c == 8'h05) m_pulses++;
        if (nbits >= 16 && c == 8'h04) m_rdata = tx_b[1];
    endtask

    task automatic settle();
        repeat (SYNC + 6) @(negedge clk);
        chk("wend_count", pulses, m_pulses);
        quiet = 1'b1;
    endtask

    task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1);
        tx_b.delete();
        tx_b.push_back(b0);
        tx_b.push_back(b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_miso", int'(spi_miso), 0);
        chk("rst_rdata", int'(wait_rdata), 8'hFF);
        chk("rst_wend", int'(wait_end), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        quiet = 1'b1;

        spiint_n = 1'b0; wait_status = 2'b10; wait_status_wrn = 1'b1;
        set_tx(8'h01, 8'h00);
        session(16, 3);
        chk("status_lit", int'(rx_b[0]), 8'hC2);
        settle();

        wait_addr = 8'h5A; wait_wdata = 8'h3C;
        set_tx(8'h02, 8'h00);
        session(16, 3);
        chk("addr_lit", int'(rx_b[0]), 8'h5A);
        settle();
        set_tx(8'h03, 8'hFF);
        session(24, 3);
        chk("wdata_lit", int'(rx_b[1]), 8'h3C);
        settle();
        set_tx(8'h05, 8'h00);
        session(8, 3);
        settle();
        chk("end_one_lit", pulses, 1);

        set_tx(8'h04, 8'h11);
        session(13, 3);
        settle();
        chk("abort_rdata_lit", int'(wait_rdata), 8'hFF);
        set_tx(8'h05, 8'h00);
        session(4, 3);
        settle();

        set_tx(8'h04, 8'hA7);
        tx_b.push_back(8'h3E);
        session(24, 3);
        settle();
        chk("rdata_lit", int'(wait_rdata), 8'hA7);
        set_tx(8'h05, 8'h00);
        session(8, 3);
        settle();
        chk("end_two_lit", pulses, 2);

        set_tx(8'h7E, 8'h55);
        session(16, 3);
        chk("unk_lit", int'(rx_b[0]), 8'hFF);
        settle();

        for (int i = 0; i < 6; i++) begin
            spi_sck = ~spi_sck;
            repeat (2) @(negedge clk);
        end
        spi_sck = 1'b0;
        settle();

        set_tx(8'h05, 8'h00);
        cs_start(3);
        clock_bits(4, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", int'(spi_miso), 0);
        chk("mid_rst_rdata", int'(wait_rdata), 8'hFF);
        chk("mid_rst_wend", int'(wait_end), 0);
        m_rdata = 8'hFF;
        repeat (3) @(negedge clk);
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        settle();

        spiint_n = 1'b1; wait_status = 2'b01; wait_status_wrn = 1'b0;
        set_tx(8'h05, 8'h00);
        session(8, 2);
        repeat (4) @(negedge clk);
        set_tx(8'h01, 8'h00);
        session(16, 2);
        chk("b2b_status_lit", int'(rx_b[0]), 8'h01);
        settle();
        chk("b2b_end_lit", pulses, 3);

        for (int n = 0; n < 40; n++) begin
            int sel;
            spiint_n = 1'($urandom);
            wait_status = 2'($urandom);
            wait_status_wrn = 1'($urandom);
            wait_addr = 8'($urandom);
            wait_wdata = 8'($urandom);
            sel = $urandom_range(0, 6);
            tx_b.delete();
            for (int k = 0; k < 4; k++) tx_b.push_back(8'($urandom));
            if (sel >= 1 && sel <= 5) tx_b[0] = 8'(sel);
            session($urandom_range(0, 30), $urandom_range(2, 4));
            settle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
